alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/writeback sequencer between decode and the ALU datapath. Accepts one op per cycle
//  (valid/ready), routes single-cycle ops to the ALU and MUL to the pipelined multiplier,
//  and tracks in-flight MULs. Arbitrates the single writeback port and blocks WAW hazards.
// PARAMETERS
//  MUL_LAT  3  multiplier latency in cycles, issue->result; legal range 2..8
//  REG_AW   5  register-index width
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset
//  req_valid   in   1       decode presents an op
//  req_ready   out  1       op accepted this cycle when req_valid & req_ready
//  req_op      in   7       ALU opcode (MUL = 7'b0000010; every other code is single-cycle)
//  req_rd      in   REG_AW  destination register; 0 = no writeback hazard tracking
//  flush       in   1       kill all in-flight and pending results (sync)
//  alu_go      out  1       single-cycle op launched to the ALU this cycle
//  mul_go      out  1       MUL launched to the multiplier this cycle
//  op_q        out  7       registered opcode of the launched op
//  wb_valid    out  1       writeback this cycle
//  wb_sel      out  1       0 = ALU result, 1 = multiplier result
//  wb_rd       out  REG_AW  writeback destination
//  busy        out  1       any MUL in flight
// BEHAVIOUR
//  - Reset (rst = 0, asynchronous, active-low; clock clk): every output 0; MUL pipe tags cleared.
//  - MUL tracking: shift register vld[1..MUL_LAT] with rd tag per stage. Accepted MUL enters
//    stage 1; advances every cycle. When stage MUL_LAT is valid: wb_valid=1, wb_sel=1,
//    wb_rd=tag, registered. This gives MUL_LAT cycles from acceptance to wb_valid.
//  - Single-cycle op: accepted at t gives alu_go=1 and op_q at t+1, and wb_valid/wb_sel=0/wb_rd at t+1.
//  - Port conflict: single-cycle op NOT accepted at t if MUL stage MUL_LAT-1 is valid at t
//    (the MUL owns the port at t+1). A MUL is never blocked by the port; latency is fixed.
//  - WAW: any op with req_rd != 0 matching a valid in-flight MUL tag gives req_ready=0.
//  - req_ready combinational from the current pipe state and req_op/req_rd; it drops
//    only for conflict, WAW or flush. Back-to-back MULs are accepted every cycle.
//  - Unknown opcodes are accepted as single-cycle ops. The ALU returns 0; the controller
//    does not filter them.
//  - flush = 1: req_ready=0; all vld stages cleared at the next edge; wb_valid=0 the next
//    cycle. Flush with wb due at the same edge kills that writeback. A req accepted in
//    the same cycle is impossible.
//  - busy = OR of vld stages. No internal FSM beyond the pipe: the state is the vld vector
//    (IDLE = all 0, BUSY = any 1).
//  - Reset mid-operation discards all in-flight ops; no writeback after reset release.
// CONFIGURATION
//  ALU_PERF_CNT_EN defined: adds outputs perf_issued[31:0] (accepted ops) and
//  perf_stall[31:0] (cycles with req_valid & !req_ready). Both are wrap-around counters,
//  reset to 0 and not cleared by flush.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package alu_pkg: ALU opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
//  OP_XOR), WB_SEL_ALU/WB_SEL_MUL encodings, and REG_AW default. Reused by the ALU and decode.
//  One sub-module: mul_tag_pipe (vld + rd-tag shift register with flush and tag-match output).
// TESTING
//  1 Reset: hold rst = 0 with req_valid = 1 -> all outputs 0. Release: first ADD rd=3 gives
//    wb_valid at the next edge with wb_sel = 0 and wb_rd = 3.
//  2 MUL rd=5 at t0 with MUL_LAT = 3 -> mul_go at t0+1, wb_valid/wb_sel=1/wb_rd=5 at t0+3, busy for t0+1..t0+3.
//  3 MUL rd=5 at t0, then ADD rd=6 at t0+2 -> req_ready=0 at t0+2 (port conflict).
//    The ADD is accepted at t0+3 and writes back at t0+4.
//  4 MUL rd=7 in flight, then SUB rd=7 -> req_ready=0 until the MUL writes back. With rd=0
//    the SUB is accepted immediately.
//  5 Three back-to-back MULs rd=1,2,3, then flush at t0+2 -> only rd=1 writes back if
//    due before the flush edge, else none. busy=0 after the flush.
//  6 With ALU_PERF_CNT_EN: run scenario 3 -> perf_issued = 2 and perf_stall = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, writeback-select encodings and default register-index width.
// Used by the issue controller, the ALU datapath and decode.
package alu_pkg;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [6:0] OP_ADD = 7'b0000000;
  localparam logic [6:0] OP_SUB = 7'b0000001;
  localparam logic [6:0] OP_MUL = 7'b0000010;
  localparam logic [6:0] OP_AND = 7'b0000011;
  localparam logic [6:0] OP_OR  = 7'b0000100;
  localparam logic [6:0] OP_XOR = 7'b0000101;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MUL = 1'b1;

  function automatic logic is_mul(input logic [6:0] op);
    return op == OP_MUL;
  endfunction
endpackage

// File: rtl/mul_tag_pipe.sv
// In-flight multiplier tracker: valid + rd-tag shift register, stage 1 = just issued,
// stage MUL_LAT = writing back this cycle. Flush clears every stage at the next edge.
module mul_tag_pipe import alu_pkg::*; #(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic [REG_AW-1:0]  match_rd_i,
  output logic [MUL_LAT:1]   vld_o,
  output logic [REG_AW-1:0]  tag_last_o,
  output logic               match_o
);
  logic [MUL_LAT:1]             vld_pipe_q, vld_pipe_d;
  logic [MUL_LAT:1][REG_AW-1:0] tag_q, tag_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[MUL_LAT-1:1], push_i};
    tag_d      = {tag_q[MUL_LAT-1:1], (push_i ? rd_i : '0)};
    if (flush_i) vld_pipe_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      tag_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_q      <= tag_d;
    end
  end

  // rd 0 never creates a hazard
  always_comb begin
    match_o = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++)
      if (vld_pipe_q[k] && (tag_q[k] == match_rd_i) && (match_rd_i != '0)) match_o = 1'b1;
  end

  assign vld_o      = vld_pipe_q;
  assign tag_last_o = tag_q[MUL_LAT];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer: single-cycle ops to the ALU, MUL to the pipelined multiplier,
// one shared writeback port, WAW blocking. ALU_PERF_CNT_EN adds issue/stall counters.
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              flush,
  output logic              alu_go,
  output logic              mul_go,
  output logic [6:0]        op_q,
  output logic              wb_valid,
  output logic              wb_sel,
  output logic [REG_AW-1:0] wb_rd,
`ifdef ALU_PERF_CNT_EN
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy
);
  logic [MUL_LAT:1]  vld;
  logic [REG_AW-1:0] tag_last;
  logic              waw, port_conflict, accept, req_mul;
  logic              alu_go_q;
  logic [REG_AW-1:0] alu_rd_q;
  logic [6:0]        op_q_r;

  assign req_mul = is_mul(req_op);

  mul_tag_pipe #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_i     (accept & req_mul),
    .rd_i       (req_rd),
    .match_rd_i (req_rd),
    .vld_o      (vld),
    .tag_last_o (tag_last),
    .match_o    (waw)
  );

  // a MUL due next cycle owns the writeback port; MULs themselves are never delayed
  assign port_conflict = !req_mul && vld[MUL_LAT-1];
  assign req_ready     = rst && !flush && !waw && !port_conflict;
  assign accept        = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_go_q <= 1'b0;
      alu_rd_q <= '0;
      op_q_r   <= '0;
    end else begin
      alu_go_q <= accept && !req_mul;
      alu_rd_q <= (accept && !req_mul) ? req_rd : '0;
      if (accept) op_q_r <= req_op;
    end
  end

  assign alu_go   = alu_go_q;
  assign mul_go   = vld[1];
  assign op_q     = op_q_r;
  assign busy     = |vld;
  assign wb_valid = vld[MUL_LAT] || alu_go_q;
  assign wb_sel   = vld[MUL_LAT] ? WB_SEL_MUL : WB_SEL_ALU;
  assign wb_rd    = vld[MUL_LAT] ? tag_last : alu_rd_q;

`ifdef ALU_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept)                 perf_issued_q <= perf_issued_q + 32'd1;
      if (req_valid && !req_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule
